// File: rtl/regfile_param.sv
// Parametrised register file with write-to-read bypass, optional hardwired zero
// register and a per-register busy scoreboard for RAW hazard stalls.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] readAddr,
  output logic [NUM_RD*DATA_W-1:0] readData,
  output logic [NUM_RD-1:0]        readBusy,
  input  logic [ADDR_W-1:0]        writeAddr,
  input  logic [DATA_W-1:0]        writeData,
  input  logic                     regwe,
  input  logic [ADDR_W-1:0]        issueAddr,
  input  logic                     issueValid,
  output logic [ADDR_W:0]          busyCount
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic [ADDR_W:0]   busy_pop;
  logic              write_en;
  logic              issue_en;

  assign write_en = regwe && !((ZERO_REG != 0) && (writeAddr == '0));
  assign issue_en = issueValid && !((ZERO_REG != 0) && (issueAddr == '0));

  // Writeback clears first so a same-edge issue to the same register wins.
  always_comb begin
    busy_next = busy;
    if (regwe)
      busy_next[writeAddr] = 1'b0;
    if (issue_en)
      busy_next[issueAddr] = 1'b1;
    busy_pop = '0;
    for (int j = 0; j < DEPTH; j++)
      busy_pop = busy_pop + {{ADDR_W{1'b0}}, busy_next[j]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++)
        regs[k] <= '0;
      busy      <= '0;
      busyCount <= '0;
    end else begin
      if (write_en)
        regs[writeAddr] <= writeData;
      busy      <= busy_next;
      busyCount <= busy_pop;
    end
  end

  // Forwarding is gated by rst_n so that outputs read zero throughout reset.
  always_comb begin
    readData = '0;
    readBusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      logic [ADDR_W-1:0] addr;
      logic              hit;
      addr = readAddr[i*ADDR_W +: ADDR_W];
      hit  = (BYPASS != 0) && rst_n && write_en && (writeAddr == addr);
      readData[i*DATA_W +: DATA_W] = hit ? writeData : regs[addr];
      readBusy[i] = busy[addr] && !hit;
      if ((ZERO_REG != 0) && (addr == '0)) begin
        readData[i*DATA_W +: DATA_W] = '0;
        readBusy[i] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Scoreboard bench: unit A (4 ports, zero reg, bypass) and unit B (2 ports,
// ordinary r0, no bypass) share one write/issue stream.
module tb_regfile_param;

  logic        clk;
  logic        rst_n;
  logic [15:0] rd_addr_a;
  logic [127:0] rd_data_a;
  logic [3:0]  rd_busy_a;
  logic [4:0]  busy_count_a;
  logic [7:0]  rd_addr_b;
  logic [63:0] rd_data_b;
  logic [1:0]  rd_busy_b;
  logic [4:0]  busy_count_b;
  logic [3:0]  write_addr;
  logic [31:0] write_data;
  logic        reg_we;
  logic [3:0]  issue_addr;
  logic        issue_valid;

  regfile_param #(.DATA_W(32), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .readAddr(rd_addr_a), .readData(rd_data_a), .readBusy(rd_busy_a),
    .writeAddr(write_addr), .writeData(write_data), .regwe(reg_we),
    .issueAddr(issue_addr), .issueValid(issue_valid), .busyCount(busy_count_a)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .readAddr(rd_addr_b), .readData(rd_data_b), .readBusy(rd_busy_b),
    .writeAddr(write_addr), .writeData(write_data), .regwe(reg_we),
    .issueAddr(issue_addr), .issueValid(issue_valid), .busyCount(busy_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          unit;
    int          kind;
    int          port;
    logic [31:0] value;
  } exp_t;

  exp_t  exp_q [$];
  string name_q [$];
  int    vectors     = 0;
  int    miscompares = 0;
  event  check_ev;

  localparam int A = 0, B = 1;
  localparam int DATA = 0, BUSY = 1, COUNT = 2;

  function automatic logic [31:0] getActual(input int unit, input int kind, input int port);
    logic [31:0] v;
    v = '0;
    if (unit == A) begin
      case (kind)
        DATA:    v = rd_data_a[port*32 +: 32];
        BUSY:    v = {31'd0, rd_busy_a[port]};
        default: v = {27'd0, busy_count_a};
      endcase
    end else begin
      case (kind)
        DATA:    v = rd_data_b[port*32 +: 32];
        BUSY:    v = {31'd0, rd_busy_b[port]};
        default: v = {27'd0, busy_count_b};
      endcase
    end
    return v;
  endfunction

  // Monitor: drains every pending expectation when a sample point is signalled.
  initial begin
    exp_t        e;
    string       nm;
    logic [31:0] act;
    forever begin
      @(check_ev);
      while (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        act = getActual(e.unit, e.kind, e.port);
        vectors++;
        if (act !== e.value) begin
          miscompares++;
          $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, e.value);
        end
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [3:0] wa, input logic [31:0] wd,
                               input logic iv, input logic [3:0] ia);
    @(negedge clk);
    reg_we      = we;
    write_addr  = wa;
    write_data  = wd;
    issue_valid = iv;
    issue_addr  = ia;
  endtask

  task automatic setReadA(input int port, input logic [3:0] addr);
    rd_addr_a[port*4 +: 4] = addr;
  endtask

  task automatic setReadB(input int port, input logic [3:0] addr);
    rd_addr_b[port*4 +: 4] = addr;
  endtask

  task automatic expectVal(input int unit, input int kind, input int port,
                           input logic [31:0] value, input string name);
    exp_t e;
    e.unit  = unit;
    e.kind  = kind;
    e.port  = port;
    e.value = value;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic checkOutput();
    #1;
    -> check_ev;
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    rd_addr_a = '0;
    rd_addr_b = '0;
    reg_we = 1'b0; write_addr = '0; write_data = '0;
    issue_valid = 1'b0; issue_addr = '0;

    // Held in reset: write and issue must be discarded, outputs zero.
    applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 4'd7);
    setReadA(0, 4'd5); setReadA(1, 4'd7); setReadB(0, 4'd5);
    expectVal(A, DATA, 0, 32'h0, "rst_a_data");
    expectVal(A, BUSY, 1, 32'h0, "rst_a_busy");
    expectVal(A, COUNT, 0, 32'h0, "rst_a_count");
    expectVal(B, DATA, 0, 32'h0, "rst_b_data");
    checkOutput();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    expectVal(A, DATA, 0, 32'h0, "rst_discard_a");
    expectVal(B, DATA, 0, 32'h0, "rst_discard_b");
    expectVal(B, COUNT, 0, 32'h0, "rst_discard_b_count");
    checkOutput();
    rst_n = 1'b1;

    applyStimulus(1'b1, 4'd5, 32'hDEADBEEF, 1'b1, 4'd7);
    expectVal(A, DATA, 0, 32'hDEADBEEF, "r5_bypass_a");
    expectVal(B, DATA, 0, 32'h0, "r5_nobypass_b");
    expectVal(A, BUSY, 1, 32'h0, "r7_notyet_busy");
    checkOutput();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    expectVal(A, DATA, 0, 32'hDEADBEEF, "r5_stored_a");
    expectVal(B, DATA, 0, 32'hDEADBEEF, "r5_stored_b");
    expectVal(A, BUSY, 1, 32'h1, "r7_busy");
    expectVal(A, COUNT, 0, 32'h1, "count_r7_a");
    expectVal(B, COUNT, 0, 32'h1, "count_r7_b");
    checkOutput();

    // Mid-cycle asynchronous reset pulse, checked before any clock edge.
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    #1 rst_n = 1'b0;
    expectVal(A, DATA, 0, 32'h0, "async_rst_data_a");
    expectVal(A, BUSY, 1, 32'h0, "async_rst_busy_a");
    expectVal(A, COUNT, 0, 32'h0, "async_rst_count_a");
    expectVal(B, DATA, 0, 32'h0, "async_rst_data_b");
    expectVal(B, COUNT, 0, 32'h0, "async_rst_count_b");
    checkOutput();
    rst_n = 1'b1;

    // Zero register: dropped in A, ordinary (and a collision) in B.
    applyStimulus(1'b1, 4'd0, 32'h12345678, 1'b1, 4'd0);
    setReadA(0, 4'd0); setReadB(0, 4'd0);
    expectVal(A, DATA, 0, 32'h0, "r0_bypass_a");
    expectVal(A, BUSY, 0, 32'h0, "r0_busy_a");
    expectVal(B, DATA, 0, 32'h0, "r0_old_b");
    checkOutput();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    expectVal(A, DATA, 0, 32'h0, "r0_after_a");
    expectVal(A, COUNT, 0, 32'h0, "r0_count_a");
    expectVal(B, DATA, 0, 32'h12345678, "r0_after_b");
    expectVal(B, BUSY, 0, 32'h1, "r0_collision_busy_b");
    expectVal(B, COUNT, 0, 32'h1, "r0_count_b");
    checkOutput();

    applyStimulus(1'b1, 4'd3, 32'hA5A5A5A5, 1'b0, 4'd0);
    setReadA(0, 4'd3); setReadB(0, 4'd3);
    expectVal(A, DATA, 0, 32'hA5A5A5A5, "r3_bypass_a");
    expectVal(B, DATA, 0, 32'h0, "r3_old_b");
    checkOutput();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    expectVal(A, DATA, 0, 32'hA5A5A5A5, "r3_after_a");
    expectVal(B, DATA, 0, 32'hA5A5A5A5, "r3_after_b");
    checkOutput();

    // Scoreboard: issue r4, idle, then writeback r4.
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b1, 4'd4);
    setReadA(1, 4'd4); setReadB(1, 4'd4);
    expectVal(A, BUSY, 1, 32'h0, "r4_issue_cycle");
    checkOutput();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    expectVal(A, BUSY, 1, 32'h1, "r4_busy_a");
    expectVal(A, COUNT, 0, 32'h1, "r4_count_a");
    expectVal(B, BUSY, 1, 32'h1, "r4_busy_b");
    expectVal(B, COUNT, 0, 32'h2, "r4_count_b");
    checkOutput();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    applyStimulus(1'b1, 4'd4, 32'hCAFEF00D, 1'b0, 4'd0);
    expectVal(A, BUSY, 1, 32'h0, "r4_wb_bypass_busy_a");
    expectVal(A, DATA, 1, 32'hCAFEF00D, "r4_wb_bypass_data_a");
    expectVal(A, COUNT, 0, 32'h1, "r4_wb_count_a");
    expectVal(B, BUSY, 1, 32'h1, "r4_wb_busy_b");
    expectVal(B, DATA, 1, 32'h0, "r4_wb_old_b");
    checkOutput();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    expectVal(A, BUSY, 1, 32'h0, "r4_cleared_a");
    expectVal(A, COUNT, 0, 32'h0, "r4_cleared_count_a");
    expectVal(B, BUSY, 1, 32'h0, "r4_cleared_b");
    expectVal(B, COUNT, 0, 32'h1, "r4_cleared_count_b");
    expectVal(B, DATA, 1, 32'hCAFEF00D, "r4_data_b");
    checkOutput();

    // Collision on r9, re-issue while busy, then a single writeback.
    applyStimulus(1'b1, 4'd9, 32'h99990000, 1'b1, 4'd9);
    setReadA(2, 4'd9);
    expectVal(A, BUSY, 2, 32'h0, "r9_collide_cycle");
    checkOutput();
    applyStimulus(1'b1, 4'd0, 32'h0, 1'b1, 4'd9);
    expectVal(A, DATA, 2, 32'h99990000, "r9_data");
    expectVal(A, BUSY, 2, 32'h1, "r9_still_busy");
    expectVal(A, COUNT, 0, 32'h1, "r9_count_a");
    expectVal(B, COUNT, 0, 32'h2, "r9_count_b");
    checkOutput();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    expectVal(A, BUSY, 2, 32'h1, "r9_reissue_busy");
    expectVal(A, COUNT, 0, 32'h1, "r9_reissue_count");
    expectVal(B, COUNT, 0, 32'h1, "r9_r0_cleared_b");
    checkOutput();
    applyStimulus(1'b1, 4'd9, 32'h9999AAAA, 1'b0, 4'd0);
    expectVal(A, BUSY, 2, 32'h0, "r9_wb_bypass");
    checkOutput();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    expectVal(A, BUSY, 2, 32'h0, "r9_cleared");
    expectVal(A, COUNT, 0, 32'h0, "r9_cleared_count");
    checkOutput();

    // Multi-port: every port reads r2 across two writes.
    applyStimulus(1'b1, 4'd2, 32'h0F0F0F0F, 1'b0, 4'd0);
    for (int p = 0; p < 4; p++) setReadA(p, 4'd2);
    for (int p = 0; p < 2; p++) setReadB(p, 4'd2);
    for (int p = 0; p < 4; p++) expectVal(A, DATA, p, 32'h0F0F0F0F, $sformatf("mp_bypass_a%0d", p));
    for (int p = 0; p < 2; p++) expectVal(B, DATA, p, 32'h0, $sformatf("mp_old_b%0d", p));
    checkOutput();
    applyStimulus(1'b1, 4'd2, 32'h11111111, 1'b0, 4'd0);
    for (int p = 0; p < 4; p++) expectVal(A, DATA, p, 32'h11111111, $sformatf("mp_bypass2_a%0d", p));
    for (int p = 0; p < 2; p++) expectVal(B, DATA, p, 32'h0F0F0F0F, $sformatf("mp_prev_b%0d", p));
    checkOutput();
    applyStimulus(1'b0, 4'd0, 32'h0, 1'b0, 4'd0);
    for (int p = 0; p < 4; p++) expectVal(A, DATA, p, 32'h11111111, $sformatf("mp_final_a%0d", p));
    for (int p = 0; p < 2; p++) expectVal(B, DATA, p, 32'h11111111, $sformatf("mp_final_b%0d", p));
    checkOutput();

    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
